// File: rtl/cam_entry_writer.sv
// cam_entry_writer: update-side controller for a two-slice transposed CAM.
// Each request read-modify-writes both slice RAMs to set or clear one entry's
// bit. A per-entry shadow key lets erase and overwrite find the old word
// without the requester supplying it. After reset the slice RAMs are swept to zero.
module cam_entry_writer #(
    parameter int DATA_WIDTH  = 15,
    parameter int ADDR_WIDTH  = 24,
    parameter int SLICE_WIDTH = 12,
    parameter int IDX_W       = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_op,
    input  logic [ADDR_WIDTH-1:0] req_key,
    input  logic [IDX_W-1:0]      req_idx,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic                  resp_replaced,
    output logic                  busy,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din0,
    output logic [DATA_WIDTH-1:0] ram_din1,
    input  logic [DATA_WIDTH-1:0] ram_dout0,
    input  logic [DATA_WIDTH-1:0] ram_dout1
);

    localparam logic [SLICE_WIDTH-1:0] SWEEP_LAST  = '1;
    localparam logic [IDX_W:0]         ENTRY_LIMIT = (IDX_W+1)'(DATA_WIDTH);
    localparam logic                   OP_ERASE    = 1'b1;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RD_OLD,
        S_CLR_OLD,
        S_RD_NEW,
        S_SET_NEW,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [SLICE_WIDTH-1:0]  cnt_q, cnt_d;
    logic                    op_q, op_d;
    logic [ADDR_WIDTH-1:0]   key_q, key_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    err_q, err_d;
    logic                    repl_q, repl_d;
    logic [DATA_WIDTH-1:0]   entry_valid_q, entry_valid_d;

    logic                    ram_en_q, ram_en_d;
    logic                    ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic                    req_ready_q, req_ready_d;
    logic                    busy_q, busy_d;
    logic                    resp_valid_q, resp_valid_d;
    logic                    resp_err_q, resp_err_d;
    logic                    resp_replaced_q, resp_replaced_d;

    // Shadow copy of the key stored by each entry; only meaningful where entry_valid is set.
    logic [ADDR_WIDTH-1:0]   shadow_key_q [DATA_WIDTH];
    logic                    shadow_we;
    logic [ADDR_WIDTH-1:0]   shadow_old;
    logic [DATA_WIDTH-1:0]   mask;

    assign mask = DATA_WIDTH'(1) << idx_q;

    // Old key of the entry being addressed next cycle; guarded so an
    // out-of-range index never reads past the table.
    always_comb begin
        shadow_old = '0;
        if ({1'b0, idx_d} < ENTRY_LIMIT) begin
            shadow_old = shadow_key_q[idx_d];
        end
    end

    // Next-state, request latching and registered-output computation.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        op_d            = op_q;
        key_d           = key_q;
        idx_d           = idx_q;
        err_d           = err_q;
        repl_d          = repl_q;
        entry_valid_d   = entry_valid_q;
        shadow_we       = 1'b0;

        case (state_q)
            S_INIT: begin
                if (cnt_q == SWEEP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (req_valid) begin
                    op_d   = req_op;
                    key_d  = req_key;
                    idx_d  = req_idx;
                    err_d  = 1'b0;
                    repl_d = 1'b0;
                    if ({1'b0, req_idx} >= ENTRY_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (entry_valid_q[req_idx]) begin
                        repl_d  = 1'b1;
                        state_d = S_RD_OLD;
                    end else if (req_op == OP_ERASE) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD_NEW;
                    end
                end
            end
            S_RD_OLD: begin
                state_d = S_CLR_OLD;
            end
            S_CLR_OLD: begin
                entry_valid_d[idx_q] = 1'b0;
                state_d = (op_q == OP_ERASE) ? S_DONE : S_RD_NEW;
            end
            S_RD_NEW: begin
                state_d = S_SET_NEW;
            end
            S_SET_NEW: begin
                entry_valid_d[idx_q] = 1'b1;
                shadow_we = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the state being entered so they line up with it.
        ram_en_d        = (state_d == S_RD_OLD) || (state_d == S_RD_NEW);
        ram_we_d        = (state_d == S_INIT) || (state_d == S_CLR_OLD) || (state_d == S_SET_NEW);
        req_ready_d     = (state_d == S_IDLE);
        busy_d          = (state_d != S_IDLE);
        resp_valid_d    = (state_d == S_DONE);
        resp_err_d      = (state_d == S_DONE) && err_d;
        resp_replaced_d = (state_d == S_DONE) && repl_d;

        case (state_d)
            S_INIT:              ram_addr_d = {cnt_d, cnt_d};
            S_RD_OLD, S_CLR_OLD: ram_addr_d = shadow_old;
            S_RD_NEW, S_SET_NEW: ram_addr_d = key_d;
            default:             ram_addr_d = '0;
        endcase
    end

    // Controller state and registered outputs; reset restarts the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_INIT;
            cnt_q           <= '0;
            op_q            <= 1'b0;
            key_q           <= '0;
            idx_q           <= '0;
            err_q           <= 1'b0;
            repl_q          <= 1'b0;
            entry_valid_q   <= '0;
            ram_en_q        <= 1'b0;
            ram_we_q        <= 1'b1;
            ram_addr_q      <= '0;
            req_ready_q     <= 1'b0;
            busy_q          <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_err_q      <= 1'b0;
            resp_replaced_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            op_q            <= op_d;
            key_q           <= key_d;
            idx_q           <= idx_d;
            err_q           <= err_d;
            repl_q          <= repl_d;
            entry_valid_q   <= entry_valid_d;
            ram_en_q        <= ram_en_d;
            ram_we_q        <= ram_we_d;
            ram_addr_q      <= ram_addr_d;
            req_ready_q     <= req_ready_d;
            busy_q          <= busy_d;
            resp_valid_q    <= resp_valid_d;
            resp_err_q      <= resp_err_d;
            resp_replaced_q <= resp_replaced_d;
        end
    end

    // Shadow key table: captured when the new bit is committed to the slices.
    always_ff @(posedge clk) begin
        if (shadow_we) begin
            shadow_key_q[idx_q] <= key_q;
        end
    end

    // Write data depends on the word read the previous cycle, so it is formed
    // from ram_dout in the write state itself; zero outside CAM writes.
    always_comb begin
        ram_din0 = '0;
        ram_din1 = '0;
        if (state_q == S_CLR_OLD) begin
            ram_din0 = ram_dout0 & ~mask;
            ram_din1 = ram_dout1 & ~mask;
        end else if (state_q == S_SET_NEW) begin
            ram_din0 = ram_dout0 | mask;
            ram_din1 = ram_dout1 | mask;
        end
    end

    assign req_ready     = req_ready_q;
    assign busy          = busy_q;
    assign resp_valid    = resp_valid_q;
    assign resp_err      = resp_err_q;
    assign resp_replaced = resp_replaced_q;
    assign ram_en        = ram_en_q;
    assign ram_we        = ram_we_q;
    assign ram_addr      = ram_addr_q;

endmodule

// File: tb/tb_cam_entry_writer.sv
// Directed bench for cam_entry_writer with a two-slice registered-read RAM model.
module tb_cam_entry_writer;

    localparam int DW = 15;
    localparam int AW = 24;
    localparam int SW = 12;
    localparam int IW = 4;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_op;
    logic [AW-1:0] req_key;
    logic [IW-1:0] req_idx;
    logic          resp_valid;
    logic          resp_err;
    logic          resp_replaced;
    logic          busy;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din0;
    logic [DW-1:0] ram_din1;
    logic [DW-1:0] ram_dout0;
    logic [DW-1:0] ram_dout1;

    int errors = 0;
    int checks = 0;

    cam_entry_writer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .SLICE_WIDTH(SW),
        .IDX_W      (IW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_key      (req_key),
        .req_idx      (req_idx),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_replaced(resp_replaced),
        .busy         (busy),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_din0     (ram_din0),
        .ram_din1     (ram_din1),
        .ram_dout0    (ram_dout0),
        .ram_dout1    (ram_dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slice RAM model, registered read.
    logic [DW-1:0] mem0 [4096];
    logic [DW-1:0] mem1 [4096];

    always @(posedge clk) begin
        if (ram_en) begin
            ram_dout0 <= mem0[ram_addr[11:0]];
            ram_dout1 <= mem1[ram_addr[23:12]];
        end
        if (ram_we) begin
            mem0[ram_addr[11:0]]  <= ram_din0;
            mem1[ram_addr[23:12]] <= ram_din1;
        end
    end

    // Bus monitor: traffic counts, write log, protocol violations.
    int            rd_cnt = 0;
    int            wr_cnt = 0;
    int            viol_cnt = 0;
    int            resp_cnt = 0;
    logic [AW-1:0] wr_addr [$];
    logic [DW-1:0] wr_d0 [$];
    logic [DW-1:0] wr_d1 [$];

    always @(posedge clk) begin
        if (rst_n) begin
            if (ram_en) rd_cnt++;
            if (ram_we) begin
                wr_cnt++;
                wr_addr.push_back(ram_addr);
                wr_d0.push_back(ram_din0);
                wr_d1.push_back(ram_din1);
            end
            if (ram_en && ram_we) viol_cnt++;
            if (!ram_en && !ram_we && ram_addr != '0) viol_cnt++;
            if (!ram_we && (ram_din0 != '0 || ram_din1 != '0)) viol_cnt++;
            if (resp_valid) resp_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic op, input logic [AW-1:0] key, input logic [IW-1:0] idx,
                          output int lat, output logic err, output logic repl);
        int w;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("req_ready_before_accept", 32'(req_ready), 32'd1);
        rd_cnt = 0;
        wr_cnt = 0;
        wr_addr.delete();
        wr_d0.delete();
        wr_d1.delete();
        req_valid = 1'b1;
        req_op    = op;
        req_key   = key;
        req_idx   = idx;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat  = -1;
        err  = 1'b0;
        repl = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat  = n;
                err  = resp_err;
                repl = resp_replaced;
                break;
            end
        end
        $display("txn op=%0d key=0x%06h idx=%0d lat=%0d err=%0d repl=%0d rd=%0d wr=%0d",
                 op, key, idx, lat, err, repl, rd_cnt, wr_cnt);
    endtask

    function automatic int count_nonzero();
        int c;
        c = 0;
        for (int a = 0; a < 4096; a++) begin
            if (mem0[a] != '0) c++;
            if (mem1[a] != '0) c++;
        end
        return c;
    endfunction

    initial begin
        int   lat;
        logic err;
        logic repl;
        int   good;
        int   early;
        int   n;

        for (int a = 0; a < 4096; a++) begin
            mem0[a] = '1;
            mem1[a] = '1;
        end
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_key   = '0;
        req_idx   = '0;
        repeat (3) @(negedge clk);

        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err_repl", 32'({resp_err, resp_replaced}), 32'd0);

        // Sweep: one write of zero per cycle at {c,c}, then IDLE on cycle 4097.
        rst_n = 1'b1;
        good  = 0;
        early = 0;
        for (int k = 0; k < 4096; k++) begin
            if (ram_we && !ram_en && ram_addr == {12'(k), 12'(k)} &&
                ram_din0 == '0 && ram_din1 == '0) good++;
            if (req_ready) early++;
            @(negedge clk);
        end
        $display("init sweep strobes=%0d early_ready=%0d", good, early);
        check("init_strobes", 32'(good), 32'd4096);
        check("init_ready_early", 32'(early), 32'd0);
        check("init_ready_after", 32'(req_ready), 32'd1);
        check("init_busy_after", 32'(busy), 32'd0);
        check("init_ram_cleared", 32'(count_nonzero()), 32'd0);

        // Fresh insert 0x00A005 at idx 3.
        do_req(1'b0, 24'h00A005, 4'd3, lat, err, repl);
        check("ins3_lat", 32'(lat), 32'd3);
        check("ins3_err_repl", 32'({err, repl}), 32'd0);
        check("ins3_rd_wr", 32'({rd_cnt[7:0], wr_cnt[7:0]}), 32'h0101);
        check("ins3_addr", 32'(wr_addr[0]), 32'h00A005);
        check("ins3_din", 32'({wr_d1[0], wr_d0[0]}), {2'b0, 15'h0008, 15'h0008});
        @(negedge clk);
        check("ins3_resp_one_pulse", 32'(resp_valid), 32'd0);

        // Second entry with the same key at idx 7.
        do_req(1'b0, 24'h00A005, 4'd7, lat, err, repl);
        check("ins7_lat", 32'(lat), 32'd3);
        check("ins7_din", 32'({wr_d1[0], wr_d0[0]}), {2'b0, 15'h0088, 15'h0088});

        // Erase idx 3 leaves only idx 7's bit.
        do_req(1'b1, 24'h000000, 4'd3, lat, err, repl);
        check("era3_lat", 32'(lat), 32'd3);
        check("era3_err", 32'(err), 32'd0);
        check("era3_rd_wr", 32'({rd_cnt[7:0], wr_cnt[7:0]}), 32'h0101);
        check("era3_addr", 32'(wr_addr[0]), 32'h00A005);
        check("era3_din", 32'({wr_d1[0], wr_d0[0]}), {2'b0, 15'h0080, 15'h0080});

        // Overwrite idx 7 with 0x123456.
        do_req(1'b0, 24'h123456, 4'd7, lat, err, repl);
        check("ovw7_lat", 32'(lat), 32'd5);
        check("ovw7_err_repl", 32'({err, repl}), 32'd1);
        check("ovw7_rd_wr", 32'({rd_cnt[7:0], wr_cnt[7:0]}), 32'h0202);
        check("ovw7_clr_addr", 32'(wr_addr[0]), 32'h00A005);
        check("ovw7_clr_din", 32'({wr_d1[0], wr_d0[0]}), 32'd0);
        check("ovw7_set_addr", 32'(wr_addr[1]), 32'h123456);
        check("ovw7_set_din", 32'({wr_d1[1], wr_d0[1]}), {2'b0, 15'h0080, 15'h0080});

        // Re-insert same key at same idx: read must see the cleared word.
        do_req(1'b0, 24'h123456, 4'd7, lat, err, repl);
        check("reins7_lat", 32'(lat), 32'd5);
        check("reins7_clr_din", 32'({wr_d1[0], wr_d0[0]}), 32'd0);
        check("reins7_mem", 32'({mem1[12'h123], mem0[12'h456]}), {2'b0, 15'h0080, 15'h0080});

        // Duplicate key at idx 0 touches only its own bit.
        do_req(1'b0, 24'h123456, 4'd0, lat, err, repl);
        check("dup0_din", 32'({wr_d1[0], wr_d0[0]}), {2'b0, 15'h0081, 15'h0081});

        // Out-of-range index.
        do_req(1'b0, 24'h111111, 4'd15, lat, err, repl);
        check("idx15_lat", 32'(lat), 32'd1);
        check("idx15_err", 32'(err), 32'd1);
        check("idx15_traffic", 32'(rd_cnt + wr_cnt), 32'd0);

        // Erase of an entry that was never valid.
        do_req(1'b1, 24'h000000, 4'd2, lat, err, repl);
        check("era2_lat", 32'(lat), 32'd1);
        check("era2_err_repl", 32'({err, repl}), 32'd0);
        check("era2_traffic", 32'(rd_cnt + wr_cnt), 32'd0);

        // Reset during SET_NEW aborts without a response and resweeps.
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_key   = 24'h000001;
        req_idx   = 4'd5;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        resp_cnt  = 0;
        @(posedge clk);
        @(negedge clk);
        check("abort_in_set_new_we", 32'({ram_we, ram_addr}), {7'b0, 1'b1, 24'h000001});
        rst_n = 1'b0;
        #1;
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_busy_ready", 32'({busy, req_ready}), 32'd2);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!req_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        $display("resweep cycles=%0d resp_pulses=%0d", n, resp_cnt);
        check("resweep_cycles", 32'(n), 32'd4096);
        check("abort_no_resp", 32'(resp_cnt), 32'd0);
        check("resweep_ram_cleared", 32'(count_nonzero()), 32'd0);

        // All entries invalid after reset: erases complete immediately.
        do_req(1'b1, 24'h000000, 4'd7, lat, err, repl);
        check("post_rst_era7_lat", 32'(lat), 32'd1);
        do_req(1'b1, 24'h000000, 4'd0, lat, err, repl);
        check("post_rst_era0_lat", 32'(lat), 32'd1);
        do_req(1'b1, 24'h000000, 4'd5, lat, err, repl);
        check("post_rst_era5_lat", 32'(lat), 32'd1);

        check("bus_protocol_violations", 32'(viol_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
